// File: rtl/capture_uart_reader.sv
// Capture RAM read side: streams one buffer of WORDS 16-bit samples as a framed
// byte sequence (two header bytes, big-endian data, 8-bit additive checksum).
module capture_uart_reader #(
  parameter int unsigned WORDS  = 720,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 2,
  parameter logic [7:0]  HDR0   = 8'hA5,
  parameter logic [7:0]  HDR1   = 8'h5A
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              capture_done,
  input  logic [15:0]       ram_q,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_RD, S_WAIT, S_HI, S_LO, S_SUM
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic [15:0]       word_q;
  logic [7:0]        checksum;
  logic              xfer;
  logic              start;
  logic              last_word;
  logic              latch_now;

  assign xfer      = tx_valid & tx_ready;
  // The frame_done cycle already reads as IDLE, but a capture arriving then is
  // treated as an overrun rather than a new start.
  assign start     = (state == S_IDLE) && capture_done && !frame_done;
  assign last_word = (ram_addr == ADDR_W'(WORDS - 1));
  // WAIT spans RD_LAT cycles of RAM latency plus the latch cycle.
  assign latch_now = (state == S_WAIT) && (wait_cnt == CNT_W'(RD_LAT));
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_d  = state;
    tx_valid = 1'b0;
    tx_data  = '0;
    ram_rden = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_d = S_HDR0;
      S_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = HDR0;
        if (tx_ready) state_d = S_HDR1;
      end
      S_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = HDR1;
        if (tx_ready) state_d = S_RD;
      end
      S_RD: begin
        ram_rden = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: if (latch_now) state_d = S_HI;
      S_HI: begin
        tx_valid = 1'b1;
        tx_data  = word_q[15:8];
        if (tx_ready) state_d = S_LO;
      end
      S_LO: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (tx_ready) state_d = last_word ? S_SUM : S_RD;
      end
      S_SUM: begin
        tx_valid = 1'b1;
        tx_data  = checksum;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      ram_addr   <= '0;
      wait_cnt   <= '0;
      word_q     <= '0;
      checksum   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      frame_done <= (state == S_SUM) && xfer;

      if (start) begin
        ram_addr <= '0;
        checksum <= '0;
        overrun  <= 1'b0;
      end else if (capture_done) begin
        overrun  <= 1'b1;
      end

      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;

      if (latch_now) word_q <= ram_q;

      if ((state == S_HI) && xfer) checksum <= checksum + word_q[15:8];
      if ((state == S_LO) && xfer) begin
        checksum <= checksum + word_q[7:0];
        if (!last_word) ram_addr <= ram_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capture_uart_reader.sv
// Bench for capture_uart_reader: scoreboarded byte stream against a RAM model,
// table of fill/ready scenarios, plus overrun, reset and latency sequences.
module tb_capture_uart_reader;

  localparam int unsigned WORDS = 720;
  localparam int unsigned NBYTES = 2 * WORDS + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cd;
  logic        s_cd;
  logic [15:0] ram_q;
  logic        tx_ready;
  logic [11:0] ram_addr;
  logic        ram_rden;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rmode    = 0;
  int nbytes   = 0;
  int t2       = 0;
  int t4       = 0;
  logic [7:0] last_byte;
  logic [7:0] exp_q [$];

  always #2.5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  capture_uart_reader #(
    .WORDS(WORDS), .ADDR_W(12), .RD_LAT(2), .HDR0(8'hA5), .HDR1(8'h5A)
  ) dut (
    .Clk(clk), .Rst_n(rst_n), .capture_done(cd), .ram_q(ram_q),
    .tx_ready(tx_ready), .ram_addr(ram_addr), .ram_rden(ram_rden),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  // RAM model, latency 2: output changes only when a read result arrives.
  logic [15:0] mem [WORDS];
  logic [15:0] m_d0, m_d1, m_held;
  logic        m_v0 = 1'b0, m_v1 = 1'b0;
  always @(posedge clk) begin
    m_v0   <= ram_rden;
    m_d0   <= mem[ram_addr];
    m_v1   <= m_v0;
    m_d1   <= m_d0;
    m_held <= ram_q;
  end
  assign ram_q = m_v1 ? m_d1 : m_held;

  // Expected byte i of a counting-pattern frame, independent of any memory.
  function automatic logic [7:0] cnt_byte(input int i);
    logic [15:0] w;
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h5A;
    if (i == NBYTES - 1) return 8'h88;
    w = 16'h0100 + 16'((i - 2) / 2);
    return (((i - 2) % 2) == 0) ? w[15:8] : w[7:0];
  endfunction

  // Extra builds at RD_LAT 1 and 3, each with its own latency model.
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned L = (g == 0) ? 1 : 3;
    logic [11:0] addr;
    logic        rden, txv, bsy, fd, ovr;
    logic [7:0]  txd;
    logic [15:0] q, held;
    logic        pv [L];
    logic [15:0] pd [L];
    int          idx  = 0;
    logic        done = 1'b0;

    capture_uart_reader #(
      .WORDS(WORDS), .ADDR_W(12), .RD_LAT(L), .HDR0(8'hA5), .HDR1(8'h5A)
    ) u_dut (
      .Clk(clk), .Rst_n(rst_n), .capture_done(s_cd), .ram_q(q),
      .tx_ready(tx_ready), .ram_addr(addr), .ram_rden(rden),
      .tx_data(txd), .tx_valid(txv), .busy(bsy),
      .frame_done(fd), .overrun(ovr)
    );

    always @(posedge clk) begin
      pv[0] <= rden;
      pd[0] <= 16'h0100 + 16'(addr);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      held <= q;
    end
    assign q = pv[L-1] ? pd[L-1] : held;

    always @(negedge clk) begin
      if (rst_n && txv && tx_ready) begin
        check((g == 0) ? "lat1_byte" : "lat3_byte", {24'h0, txd}, {24'h0, cnt_byte(idx)});
        idx++;
      end
      if (fd) done = 1'b1;
    end
  end

  // ready pattern: 0 = always, 1 = one cycle in three, 2 = held low
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((cyc % 3) == 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Main monitor: scoreboard pops, hold-while-stalled, frame_done timing.
  logic       prev_stall = 1'b0;
  logic       expect_fd  = 1'b0;
  logic [7:0] held_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      expect_fd  = 1'b0;
    end else begin
      if (expect_fd || frame_done) begin
        check("frame_done", {31'h0, frame_done}, {31'h0, expect_fd});
        if (expect_fd) check("busy_at_done", {31'h0, busy}, 32'h0);
      end
      expect_fd = 1'b0;
      if (prev_stall) begin
        check("stall_valid", {31'h0, tx_valid}, 32'h1);
        check("stall_data", {24'h0, tx_data}, {24'h0, held_data});
      end
      prev_stall = tx_valid && !tx_ready;
      held_data  = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
          if (exp_q.size() == 0) expect_fd = 1'b1;
        end
        if (nbytes == 2) t2 = cyc;
        if (nbytes == 4) t4 = cyc;
        nbytes++;
        last_byte = tx_data;
      end
    end
  end

  function automatic void fill(input int pat);
    for (int k = 0; k < WORDS; k++)
      mem[k] = (pat == 0) ? 16'h0100 + 16'(k) : (pat == 1) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic void push_frame();
    logic [7:0]  s = 8'h00;
    logic [15:0] w;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int k = 0; k < WORDS; k++) begin
      w = mem[k];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      s = 8'(s + w[15:8] + w[7:0]);
    end
    exp_q.push_back(s);
  endfunction

  task automatic start_frame();
    push_frame();
    nbytes = 0;
    @(posedge clk); #1 cd = 1'b1;
    @(posedge clk); #1 cd = 1'b0;
    check("start_valid", {31'h0, tx_valid}, 32'h1);
    check("start_hdr0", {24'h0, tx_data}, 32'hA5);
    check("start_busy", {31'h0, busy}, 32'h1);
    check("start_overrun", {31'h0, overrun}, 32'h0);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", {31'h0, frame_done}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (nbytes < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("byte_wait_timeout", {31'h0, (nbytes >= target)}, 32'h1);
  endtask

  typedef struct {
    int         pat;
    int         mode;
    logic [7:0] chk;
  } vec_t;
  vec_t tbl [4];

  initial begin
    tbl[0] = '{pat: 0, mode: 0, chk: 8'h88};
    tbl[1] = '{pat: 0, mode: 1, chk: 8'h88};
    tbl[2] = '{pat: 1, mode: 0, chk: 8'h60};
    tbl[3] = '{pat: 2, mode: 0, chk: 8'h00};

    rst_n = 1'b0; cd = 1'b0; s_cd = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", {20'h0, ram_addr}, 32'h0);
    check("rst_rden", {31'h0, ram_rden}, 32'h0);
    check("rst_data", {24'h0, tx_data}, 32'h0);
    check("rst_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, frame_done}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // RD_LAT 1 and 3 builds on the counting pattern
    @(posedge clk); #1 s_cd = 1'b1;
    @(posedge clk); #1 s_cd = 1'b0;
    for (int n = 0; n < 30000 && !(g_lat[0].done && g_lat[1].done); n++) @(posedge clk);
    #1;
    check("lat1_count", g_lat[0].idx, NBYTES);
    check("lat3_count", g_lat[1].idx, NBYTES);

    for (int v = 0; v < 4; v++) begin
      fill(tbl[v].pat);
      rmode = tbl[v].mode;
      start_frame();
      wait_frame();
      check("chk_byte", {24'h0, last_byte}, {24'h0, tbl[v].chk});
      check("byte_count", nbytes, NBYTES);
      check("queue_empty", exp_q.size(), 0);
      check("end_busy", {31'h0, busy}, 32'h0);
      check("end_addr", {20'h0, ram_addr}, WORDS - 1);
      check("end_overrun", {31'h0, overrun}, 32'h0);
      if (v == 0) check("word_cycles", t4 - t2, 6);
    end
    rmode = 0;

    // capture with transmitter stalled: HDR0 holds
    fill(0);
    rmode = 2;
    start_frame();
    repeat (5) @(posedge clk);
    #1;
    check("stall_hdr_valid", {31'h0, tx_valid}, 32'h1);
    check("stall_hdr_data", {24'h0, tx_data}, 32'hA5);
    check("stall_no_read", {31'h0, ram_rden}, 32'h0);
    rmode = 0;
    wait_frame();
    check("stall_chk", {24'h0, last_byte}, 32'h88);

    // capture while busy: frame unaffected, overrun sticky until next start
    start_frame();
    wait_bytes(500);
    @(posedge clk); #1 cd = 1'b1;
    @(posedge clk); #1 cd = 1'b0;
    check("overrun_set", {31'h0, overrun}, 32'h1);
    check("overrun_busy", {31'h0, busy}, 32'h1);
    wait_frame();
    check("overrun_count", nbytes, NBYTES);
    check("overrun_sticky", {31'h0, overrun}, 32'h1);

    // reset mid-frame then restart from address 0
    start_frame();
    wait_bytes(700);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_addr", {20'h0, ram_addr}, 32'h0);
    check("mid_rst_rden", {31'h0, ram_rden}, 32'h0);
    check("mid_rst_data", {24'h0, tx_data}, 32'h0);
    check("mid_rst_done", {31'h0, frame_done}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_frame();
    wait_frame();
    check("restart_count", nbytes, NBYTES);
    check("restart_chk", {24'h0, last_byte}, 32'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_uart_reader.md
Name: capture_uart_reader

Overview:
- Read side of the 4-channel ADC capture RAM: after the capture writer signals that a full buffer (180 points x 4 channels = 720 words) is stored, this block reads every word in address order.
- Each word is serialised into a framed byte stream for the UART/SPI transmitter.
- Sits between the single-port capture RAM (read port) and the byte-wide transmitter; runs on the 200 MHz system clock.

Parameters:
- WORDS, 720, number of 16-bit words per frame (addresses 0..WORDS-1)
- ADDR_W, 12, RAM address width
- RD_LAT, 2, RAM read latency in Clk cycles from ram_addr/ram_rden to valid ram_q
- HDR0, 8'hA5, first header byte
- HDR1, 8'h5A, second header byte

Ports:
- Clk  input  1  200 MHz system clock
- Rst_n  input  1  asynchronous active-low reset
- capture_done  input  1  one-cycle pulse: capture buffer complete, start a frame
- ram_q  input  16  RAM read data, valid RD_LAT cycles after request
- tx_ready  input  1  transmitter can accept a byte this cycle
- ram_addr  output  ADDR_W  RAM read address
- ram_rden  output  1  one-cycle read request
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid
- busy  output  1  frame in progress (owns RAM read port)
- frame_done  output  1  one-cycle pulse after the checksum byte is accepted
- overrun  output  1  sticky: capture_done arrived while busy; cleared at the next frame start

Behaviour:
- Reset (async, Rst_n low): state IDLE; ram_addr=0, ram_rden=0, tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0, checksum=0, word counter=0. Reset mid-frame aborts immediately; no partial completion.
- Byte handshake: a byte transfers on a Clk edge where tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold. tx_valid never drops without a transfer except on reset.
- Frame format: HDR0, HDR1, then for word k=0..WORDS-1 ram_q[15:8] then ram_q[7:0], then CHK. CHK = 8-bit sum mod 256 of all 2*WORDS data bytes; headers are excluded. Total 2*WORDS+3 bytes (1443 by default).
- States:
  - IDLE: on capture_done go to HDR0; set busy=1, clear checksum, ram_addr=0, clear overrun.
  - HDR0: present HDR0; on transfer go to HDR1.
  - HDR1: present HDR1; on transfer go to RD.
  - RD: one cycle with ram_rden=1 at the current ram_addr; go to WAIT.
  - WAIT: count RD_LAT cycles, then register ram_q into the word latch; go to HI.
  - HI: present the high byte; on transfer add it to the checksum; go to LO.
  - LO: present the low byte; on transfer add it to the checksum. If ram_addr==WORDS-1 go to SUM; otherwise increment ram_addr and go to RD.
  - SUM: present the checksum; on transfer pulse frame_done for 1 cycle and go to IDLE.
- busy=1 in every state except IDLE. It deasserts in the same cycle frame_done is high, so a capture_done in that cycle sets overrun.
- ram_addr stays at WORDS-1 after the frame; it returns to 0 only at the next start. The word counter never exceeds WORDS-1 (no wrap inside a frame).
- capture_done while busy: ignored for sequencing; sets overrun=1.
- capture_done in IDLE with tx_ready held low: the frame starts and HDR0 stalls until tx_ready.
- Latency: capture_done to the first tx_valid is 1 cycle. With tx_ready held high, each word takes 1 (RD) + RD_LAT (WAIT) + 1 (latch) + 2 (bytes) cycles.
- ram_q is sampled only in the latch cycle; RAM data may change at any other time.

Test Plan:
- RAM preloaded with word k = 16'h0100+k (k=0..719), tx_ready always 1, capture_done pulse -> exactly 1443 bytes: A5, 5A, 01, 00, 01, 01, ... 03, CF, then CHK = sum of all data bytes mod 256; frame_done high 1 cycle after the last transfer; busy then 0.
- Same preload, tx_ready toggling 1-of-3 cycles -> identical byte sequence; tx_data stable in every valid/not-ready cycle; no byte lost or duplicated.
- All words 16'hFFFF -> CHK = (1440*255) mod 256 = 8'h60; all words 0 -> CHK = 8'h00.
- capture_done pulsed at byte 500 mid-frame -> frame continues unchanged; overrun=1 after the pulse; overrun clears at the next capture_done in IDLE.
- Rst_n pulled low at byte 700 -> all outputs return to reset values within the reset; a new capture_done restarts the frame with A5 from address 0.
- RD_LAT=1 and RD_LAT=3 builds with the counting pattern -> each data byte matches the RAM contents at its address (checks latch timing).
